// File: rtl/ctrl_hazard_pipe.sv
// rtl/ctrl_hazard_pipe.sv - hazard descriptor decode, E/M/W tracking, stall and forward selects
module ctrl_hazard_pipe #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter bit MD_EN       = 1'b1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m,
    output logic        md_start,
    output logic        md_busy
);

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;

    typedef struct packed {
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [1:0] tnew;
        logic [4:0] dst;
        logic       md_class;
        logic       start;
        logic       is_div;
    } desc_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic       unused_shamt;

    assign opcode       = instr_d[31:26];
    assign rs_f         = instr_d[25:21];
    assign rt_f         = instr_d[20:16];
    assign rd_f         = instr_d[15:11];
    assign funct        = instr_d[5:0];
    assign unused_shamt = ^instr_d[10:6];

    desc_t dec;

    always_comb begin
        dec = '{tuse_rs: TUSE_NONE, tuse_rt: TUSE_NONE, tnew: 2'd0, dst: 5'd0,
                md_class: 1'b0, start: 1'b0, is_div: 1'b0};
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_MOVZ: begin
                        dec.tuse_rs = 2'd1;
                        dec.tuse_rt = 2'd1;
                        dec.tnew    = 2'd1;
                        dec.dst     = rd_f;
                    end
                    FN_SLL, FN_SRL: begin
                        dec.tuse_rt = 2'd1;
                        dec.tnew    = 2'd1;
                        dec.dst     = rd_f;
                    end
                    FN_JR: dec.tuse_rs = 2'd0;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        if (MD_EN) begin
                            dec.tuse_rs  = 2'd1;
                            dec.tuse_rt  = 2'd1;
                            dec.md_class = 1'b1;
                            dec.start    = 1'b1;
                            dec.is_div   = funct[1];
                        end
                    end
                    FN_MFHI, FN_MFLO: begin
                        if (MD_EN) begin
                            dec.tnew     = 2'd1;
                            dec.dst      = rd_f;
                            dec.md_class = 1'b1;
                        end
                    end
                    FN_MTHI, FN_MTLO: begin
                        if (MD_EN) begin
                            dec.tuse_rs  = 2'd1;
                            dec.md_class = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: begin
                dec.tuse_rs = 2'd1;
                dec.tnew    = 2'd1;
                dec.dst     = rt_f;
            end
            OP_LW: begin
                dec.tuse_rs = 2'd1;
                dec.tnew    = 2'd2;
                dec.dst     = rt_f;
            end
            OP_SW: begin
                dec.tuse_rs = 2'd1;
                dec.tuse_rt = 2'd2;
            end
            OP_BEQ, OP_BNE: begin
                dec.tuse_rs = 2'd0;
                dec.tuse_rt = 2'd0;
            end
            OP_JAL: begin
                dec.tnew = 2'd0;
                dec.dst  = 5'd31;
            end
            OP_J: ;
            default: ;
        endcase
    end

    // Operand fields of unused sources read as $0 so they never match a producer.
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    assign rs_d = (dec.tuse_rs != TUSE_NONE) ? rs_f : 5'd0;
    assign rt_d = (dec.tuse_rt != TUSE_NONE) ? rt_f : 5'd0;

    logic [4:0]       e_dst, e_rs, e_rt;
    logic [1:0]       e_tnew;
    logic             e_start, e_div;
    logic [4:0]       m_dst, m_rt;
    logic [1:0]       m_tnew;
    logic [4:0]       w_dst;
    logic [1:0]       w_tnew;
    logic [CNT_W-1:0] md_cnt;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_dst   <= '0;
            e_tnew  <= '0;
            e_start <= 1'b0;
            e_div   <= 1'b0;
            e_rs    <= '0;
            e_rt    <= '0;
            m_dst   <= '0;
            m_tnew  <= '0;
            m_rt    <= '0;
            w_dst   <= '0;
            w_tnew  <= '0;
        end else begin
            if (stall) begin
                e_dst   <= '0;
                e_tnew  <= '0;
                e_start <= 1'b0;
                e_div   <= 1'b0;
                e_rs    <= '0;
                e_rt    <= '0;
            end else begin
                e_dst   <= dec.dst;
                e_tnew  <= dec.tnew;
                e_start <= dec.start;
                e_div   <= dec.is_div;
                e_rs    <= rs_d;
                e_rt    <= rt_d;
            end
            m_dst  <= e_dst;
            m_tnew <= tnew_dec(e_tnew);
            m_rt   <= e_rt;
            w_dst  <= m_dst;
            w_tnew <= tnew_dec(m_tnew);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (e_start) begin
            md_cnt <= e_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_start = e_start;
    assign md_busy  = MD_EN ? (md_cnt != '0) : 1'b0;

    function automatic logic late(input logic [4:0] r, input logic [1:0] tuse,
                                  input logic [4:0] dst, input logic [1:0] tnew);
        return (r != 5'd0) && (tuse != TUSE_NONE) && (r == dst) && (tnew > tuse);
    endfunction

    logic stall_rs, stall_rt, stall_md;
    assign stall_rs = late(rs_d, dec.tuse_rs, e_dst, e_tnew) || late(rs_d, dec.tuse_rs, m_dst, m_tnew);
    assign stall_rt = late(rt_d, dec.tuse_rt, e_dst, e_tnew) || late(rt_d, dec.tuse_rt, m_dst, m_tnew);
    assign stall_md = dec.md_class && (md_busy || md_start);
    assign stall    = stall_rs || stall_rt || stall_md;

    function automatic logic ready(input logic [4:0] r, input logic [4:0] dst, input logic [1:0] tnew);
        return (r != 5'd0) && (r == dst) && (tnew == 2'd0);
    endfunction

    // Priority order gives the youngest ready producer.
    always_comb begin
        fwd_rs_d = 2'd0;
        if (ready(rs_d, e_dst, e_tnew))      fwd_rs_d = 2'd1;
        else if (ready(rs_d, m_dst, m_tnew)) fwd_rs_d = 2'd2;
        else if (ready(rs_d, w_dst, w_tnew)) fwd_rs_d = 2'd3;

        fwd_rt_d = 2'd0;
        if (ready(rt_d, e_dst, e_tnew))      fwd_rt_d = 2'd1;
        else if (ready(rt_d, m_dst, m_tnew)) fwd_rt_d = 2'd2;
        else if (ready(rt_d, w_dst, w_tnew)) fwd_rt_d = 2'd3;

        fwd_rs_e = 2'd0;
        if (ready(e_rs, m_dst, m_tnew))      fwd_rs_e = 2'd2;
        else if (ready(e_rs, w_dst, w_tnew)) fwd_rs_e = 2'd3;

        fwd_rt_e = 2'd0;
        if (ready(e_rt, m_dst, m_tnew))      fwd_rt_e = 2'd2;
        else if (ready(e_rt, w_dst, w_tnew)) fwd_rt_e = 2'd3;
    end

    assign fwd_rt_m = (m_rt != 5'd0) && (m_rt == w_dst);

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// tb/tb_ctrl_hazard_pipe.sv - scoreboard bench for ctrl_hazard_pipe
module tb_ctrl_hazard_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr_d = 32'd0;
    logic        stall, fwd_rt_m, md_start, md_busy;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    ctrl_hazard_pipe #(.MULT_CYCLES(5), .DIV_CYCLES(10), .MD_EN(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .fwd_rt_m(fwd_rt_m), .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] idx;
        logic        st;
        logic [1:0]  rsd, rtd, rse, rte;
        logic        rtm, ms, mb;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_idx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check($sformatf("stall@%0d", cur.idx), 32'(stall), 32'(cur.st));
            check($sformatf("fwd_rs_d@%0d", cur.idx), 32'(fwd_rs_d), 32'(cur.rsd));
            check($sformatf("fwd_rt_d@%0d", cur.idx), 32'(fwd_rt_d), 32'(cur.rtd));
            check($sformatf("fwd_rs_e@%0d", cur.idx), 32'(fwd_rs_e), 32'(cur.rse));
            check($sformatf("fwd_rt_e@%0d", cur.idx), 32'(fwd_rt_e), 32'(cur.rte));
            check($sformatf("fwd_rt_m@%0d", cur.idx), 32'(fwd_rt_m), 32'(cur.rtm));
            check($sformatf("md_start@%0d", cur.idx), 32'(md_start), 32'(cur.ms));
            check($sformatf("md_busy@%0d", cur.idx), 32'(md_busy), 32'(cur.mb));
        end
    end

    localparam logic [31:0] NOP = 32'd0;

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step(input logic [31:0] ins, input logic st, input logic [1:0] rsd,
                        input logic [1:0] rtd, input logic [1:0] rse, input logic [1:0] rte,
                        input logic rtm, input logic ms, input logic mb);
        @(posedge clk);
        #1;
        instr_d = ins;
        step_idx++;
        sb.push_back('{idx: 16'(step_idx), st: st, rsd: rsd, rtd: rtd, rse: rse, rte: rte,
                       rtm: rtm, ms: ms, mb: mb});
    endtask

    task automatic step0(input logic [31:0] ins);
        step(ins, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            instr_d = NOP;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with lw $1 in D, then load-use with addu $2,$1,$3
        step0(i_op(6'h23, 5'd0, 5'd1, 16'd0));
        step0(i_op(6'h23, 5'd0, 5'd1, 16'd0));
        reset_n = 1'b1;
        step(r_op(5'd1, 5'd3, 5'd2, 6'h21), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step0(r_op(5'd1, 5'd3, 5'd2, 6'h21));
        step(NOP, 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        step0(NOP);
        flush(4);

        // addu $4,$5,$6 ; beq $4,$0
        step0(r_op(5'd5, 5'd6, 5'd4, 6'h21));
        step(i_op(6'h04, 5'd4, 5'd0, 16'd8), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(i_op(6'h04, 5'd4, 5'd0, 16'd8), 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(NOP, 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        flush(4);

        // jal ; jr $31
        step0({6'h03, 26'h40});
        step(r_op(5'd31, 5'd0, 5'd0, 6'h08), 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(NOP, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        step0(NOP);
        flush(4);

        // lw $7,0($0) ; sw $7,0($8)
        step0(i_op(6'h23, 5'd0, 5'd7, 16'd0));
        step0(i_op(6'h2B, 5'd8, 5'd7, 16'd0));
        step0(NOP);
        step(NOP, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        step0(NOP);
        flush(4);

        // lw $1 ; nop ; beq $1,$0 : M-stage stall then W forward into D
        step0(i_op(6'h23, 5'd0, 5'd1, 16'd0));
        step0(NOP);
        step(i_op(6'h04, 5'd1, 5'd0, 16'd4), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(i_op(6'h04, 5'd1, 5'd0, 16'd4), 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step0(NOP);
        flush(4);

        // two writers of $4, then a reader: M beats W in D, W feeds E
        step0(r_op(5'd5, 5'd6, 5'd4, 6'h21));
        step0(r_op(5'd5, 5'd6, 5'd4, 6'h21));
        step0(NOP);
        step(r_op(5'd4, 5'd4, 5'd7, 6'h21), 1'b0, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(NOP, 1'b0, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        flush(4);

        // lw $5 ; sll with rs field $5 (rs unused) -> no stall
        step0(i_op(6'h23, 5'd0, 5'd5, 16'd0));
        step0(r_op(5'd5, 5'd0, 5'd6, 6'h00));
        step0(NOP);
        flush(4);

        // mult $1,$2 ; mflo $3 : 1 start cycle + 5 busy cycles stalled
        step0(r_op(5'd1, 5'd2, 5'd0, 6'h18));
        step(r_op(5'd0, 5'd0, 5'd3, 6'h12), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(r_op(5'd0, 5'd0, 5'd3, 6'h12), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step0(r_op(5'd0, 5'd0, 5'd3, 6'h12));
        step0(NOP);
        flush(4);

        // div $1,$2 ; addu (non-MD, no stall) ; mfhi $3 : 10 busy cycles
        step0(r_op(5'd1, 5'd2, 5'd0, 6'h1A));
        step(r_op(5'd10, 5'd11, 5'd9, 6'h21), 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            step(r_op(5'd0, 5'd0, 5'd3, 6'h10), 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step0(r_op(5'd0, 5'd0, 5'd3, 6'h10));
        flush(4);

        // ori $0 ; addu $9,$0,$0 and sw ; addu reading sw rt
        step0(i_op(6'h0D, 5'd1, 5'd0, 16'd5));
        step0(r_op(5'd0, 5'd0, 5'd9, 6'h21));
        step0(NOP);
        step0(i_op(6'h2B, 5'd8, 5'd7, 16'd0));
        step0(r_op(5'd7, 5'd7, 5'd10, 6'h21));
        step0(NOP);
        step0(NOP);

        flush(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
